// File: rtl/cdf_pkg.sv
// Shared widths, tag, FSM states and write-word packing for the CDF accumulate stage
// of the histogram-equalisation pipe.
package cdf_pkg;

   localparam int DATA_W = 20;
   localparam int ADDR_W = 16;
   localparam int BUS_W  = 128;
   localparam int TAG_W  = 16;

   localparam logic [TAG_W-1:0]  CDF_TAG = 16'hAAAA;
   localparam logic [DATA_W-1:0] CDF_MAX = {DATA_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      FINISH = 2'd2
   } state_t;

   function automatic logic [BUS_W-1:0] pack_word(input logic [DATA_W-1:0] cdf);
      return {{(BUS_W-TAG_W-DATA_W){1'b0}}, CDF_TAG, cdf};
   endfunction

endpackage

// File: rtl/cdf_accumulate_if.sv
// Fetch-to-accumulate beat stream plus the CDF write port and pass results.
interface cdf_accumulate_if;
   import cdf_pkg::*;

   logic                start;
   logic [DATA_W-1:0]   AccumlateIn;
   logic                StartIn;
   logic [ADDR_W-1:0]   StoreAddressIn;
   logic                done_in;
   logic [BUS_W-1:0]    WriteBus;
   logic [ADDR_W-1:0]   WriteAddress;
   logic                WriteEnable;
   logic [DATA_W-1:0]   CdfMin;
   logic [DATA_W-1:0]   CdfTotal;
   logic                done;

   modport slave (
      input  start, AccumlateIn, StartIn, StoreAddressIn, done_in,
      output WriteBus, WriteAddress, WriteEnable, CdfMin, CdfTotal, done
   );

   modport master (
      output start, AccumlateIn, StartIn, StoreAddressIn, done_in,
      input  WriteBus, WriteAddress, WriteEnable, CdfMin, CdfTotal, done
   );

endinterface

// File: rtl/cdf_sat_add.sv
// Combinational unsigned adder that clamps to all-ones on carry-out and flags it.
module cdf_sat_add
   import cdf_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         sat
);

   logic [W:0] full;

   // Widen by one bit so the carry-out is the saturation flag.
   always_comb begin
      full = {1'b0, a} + {1'b0, b};
      sat  = full[W];
      if (sat) begin
         sum = {W{1'b1}};
      end else begin
         sum = full[W-1:0];
      end
   end

endmodule

// File: rtl/cdf_accumulate.sv
// Running-sum (CDF) stage: accumulates per-bin counts, writes each CDF word back to
// memory and reports the first non-zero CDF value and the pass total.
module cdf_accumulate
   import cdf_pkg::*;
#(
   parameter int                BINS      = 256,
   parameter logic [ADDR_W-1:0] WR_OFFSET = 16'h4000
) (
   input  logic             clock,
   input  logic             reset_n,
   cdf_accumulate_if.slave  bus
);

   localparam int             CNT_W   = $clog2(BINS + 1);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(BINS);

   state_t              state,     state_nxt;
   logic [DATA_W-1:0]   sum,       sum_nxt;
   logic [CNT_W-1:0]    cnt,       cnt_nxt;
   logic                min_found, min_found_nxt;
   logic                sat_seen,  sat_seen_nxt;
   logic [BUS_W-1:0]    wr_bus,    wr_bus_nxt;
   logic [ADDR_W-1:0]   wr_addr,   wr_addr_nxt;
   logic                wr_en,     wr_en_nxt;
   logic [DATA_W-1:0]   min_val,   min_val_nxt;
   logic [DATA_W-1:0]   total_val, total_val_nxt;
   logic                pass_done, pass_done_nxt;

   logic                accept;
   logic                clear;
   logic [DATA_W-1:0]   add_sum;
   logic                sat_hit;
   logic [DATA_W-1:0]   sum_acc;

   cdf_sat_add #(.W(DATA_W)) u_sat_add (
      .a   (sum),
      .b   (bus.AccumlateIn),
      .sum (add_sum),
      .sat (sat_hit)
   );

   // Once clamped, the sum stays at full scale for the rest of the pass.
   assign sum_acc = (sat_seen || sat_hit) ? CDF_MAX : add_sum;

   // Next-state and next-output decode; abort (start low) outranks every other input.
   always_comb begin
      state_nxt     = state;
      sum_nxt       = sum;
      cnt_nxt       = cnt;
      min_found_nxt = min_found;
      sat_seen_nxt  = sat_seen;
      wr_bus_nxt    = wr_bus;
      wr_addr_nxt   = wr_addr;
      wr_en_nxt     = 1'b0;
      min_val_nxt   = min_val;
      total_val_nxt = total_val;
      pass_done_nxt = 1'b0;
      accept        = 1'b0;
      clear         = 1'b0;

      if (!bus.start) begin
         state_nxt = IDLE;
         clear     = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               clear = 1'b1;
               if (bus.StartIn) begin
                  state_nxt = ACCUM;
                  accept    = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
            ACCUM: begin
               accept = bus.StartIn && (cnt < CNT_LIM);
               if (bus.done_in) begin
                  state_nxt = FINISH;
               end else begin
                  state_nxt = ACCUM;
               end
            end
            FINISH: begin
               total_val_nxt = sum;
               pass_done_nxt = 1'b1;
            end
            default: begin
               state_nxt = IDLE;
               clear     = 1'b1;
            end
         endcase
      end

      if (clear) begin
         sum_nxt       = '0;
         cnt_nxt       = '0;
         min_found_nxt = 1'b0;
         sat_seen_nxt  = 1'b0;
         wr_bus_nxt    = '0;
         wr_addr_nxt   = '0;
         min_val_nxt   = '0;
         total_val_nxt = '0;
         pass_done_nxt = 1'b0;
      end else begin
         cnt_nxt = cnt;
      end

      // IDLE entry relies on sum being zero, which every path into IDLE guarantees.
      if (accept) begin
         sum_nxt      = sum_acc;
         sat_seen_nxt = sat_seen || sat_hit;
         cnt_nxt      = cnt + CNT_W'(1);
         wr_bus_nxt   = pack_word(sum_acc);
         wr_addr_nxt  = bus.StoreAddressIn + WR_OFFSET;
         wr_en_nxt    = 1'b1;
         if (!min_found && (sum_acc != '0)) begin
            min_val_nxt   = sum_acc;
            min_found_nxt = 1'b1;
         end else begin
            min_found_nxt = min_found;
         end
      end else begin
         wr_en_nxt = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sum       <= '0;
         cnt       <= '0;
         min_found <= 1'b0;
         sat_seen  <= 1'b0;
         wr_bus    <= '0;
         wr_addr   <= '0;
         wr_en     <= 1'b0;
         min_val   <= '0;
         total_val <= '0;
         pass_done <= 1'b0;
      end else begin
         sum       <= sum_nxt;
         cnt       <= cnt_nxt;
         min_found <= min_found_nxt;
         sat_seen  <= sat_seen_nxt;
         wr_bus    <= wr_bus_nxt;
         wr_addr   <= wr_addr_nxt;
         wr_en     <= wr_en_nxt;
         min_val   <= min_val_nxt;
         total_val <= total_val_nxt;
         pass_done <= pass_done_nxt;
      end
   end

   assign bus.WriteBus     = wr_bus;
   assign bus.WriteAddress = wr_addr;
   assign bus.WriteEnable  = wr_en;
   assign bus.CdfMin       = min_val;
   assign bus.CdfTotal     = total_val;
   assign bus.done         = pass_done;

endmodule

// File: tb/tb_cdf_accumulate.sv
// Directed bench for cdf_accumulate: ramp, leading zeros, saturation, all-zero,
// abort, overrun with address wrap, and synchronous reset mid-pass.
module tb_cdf_accumulate;
   import cdf_pkg::*;

   logic clock = 1'b0;
   logic reset_n;

   always #5 clock = ~clock;

   cdf_accumulate_if bus ();

   cdf_accumulate dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int wr_count = 0;

   logic [19:0]  exp_data_q[$];
   logic [15:0]  exp_addr_q[$];
   logic [19:0]  mon_d;
   logic [15:0]  mon_a;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] beat_data(input int mode, input int i);
      case (mode)
         0:       return 20'd1;
         1:       return (i == 10) ? 20'd5 : 20'd0;
         2:       return 20'h10000;
         default: return 20'd0;
      endcase
   endfunction

   // Hand-derived CDF after beat i (0-based) for each stimulus pattern.
   function automatic logic [19:0] exp_cdf(input int mode, input int i);
      case (mode)
         0:       return 20'(i + 1);
         1:       return (i < 10) ? 20'd0 : 20'd5;
         2:       return (i < 15) ? 20'((i + 1) * 65536) : 20'hFFFFF;
         default: return 20'd0;
      endcase
   endfunction

   // Write monitor: each strobe must match the next expected word and never overlap done.
   always @(negedge clock) begin
      if (bus.WriteEnable === 1'b1) begin
         wr_count++;
         if (exp_data_q.size() == 0) begin
            check_eq("write_expected", 128'(bus.WriteEnable), 128'(1'b0));
         end else begin
            mon_d = exp_data_q.pop_front();
            mon_a = exp_addr_q.pop_front();
            check_eq("write_data", bus.WriteBus, {92'd0, 16'hAAAA, mon_d});
            check_eq("write_addr", 128'(bus.WriteAddress), 128'(mon_a));
         end
         if (bus.done === 1'b1) begin
            check_eq("write_vs_done", 128'(bus.done), 128'(1'b0));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_we"},    128'(bus.WriteEnable),  128'(1'b0));
      check_eq({tag, "_bus"},   bus.WriteBus,           128'(0));
      check_eq({tag, "_addr"},  128'(bus.WriteAddress), 128'(0));
      check_eq({tag, "_min"},   128'(bus.CdfMin),       128'(0));
      check_eq({tag, "_total"}, 128'(bus.CdfTotal),     128'(0));
      check_eq({tag, "_done"},  128'(bus.done),         128'(1'b0));
   endtask

   task automatic drive_beat(input int mode, input int i, input logic [15:0] base);
      bus.StartIn        = 1'b1;
      bus.AccumlateIn    = beat_data(mode, i);
      bus.StoreAddressIn = base + 16'(i);
      if (i < 256) begin
         exp_data_q.push_back(exp_cdf(mode, i));
         exp_addr_q.push_back(base + 16'(i) + 16'h4000);
      end
   endtask

   task automatic run_pass(input string tag, input int n, input logic [15:0] base,
                           input int mode, input logic [19:0] exp_min);
      int acc;
      acc = (n < 256) ? n : 256;
      wr_count = 0;
      bus.start = 1'b1;
      for (int i = 0; i < n; i++) begin
         drive_beat(mode, i, base);
         tick();
      end
      bus.StartIn = 1'b0;
      bus.done_in = 1'b1;
      tick();
      bus.done_in = 1'b0;
      check_eq({tag, "_done_early"}, 128'(bus.done), 128'(1'b0));
      tick();
      check_eq({tag, "_done"},   128'(bus.done),        128'(1'b1));
      check_eq({tag, "_we_idle"},128'(bus.WriteEnable), 128'(1'b0));
      check_eq({tag, "_total"},  128'(bus.CdfTotal),    128'(exp_cdf(mode, acc - 1)));
      check_eq({tag, "_min"},    128'(bus.CdfMin),      128'(exp_min));
      check_eq({tag, "_writes"}, 128'(wr_count),        128'(acc));
      check_eq({tag, "_pending"},128'(exp_data_q.size()), 128'(0));
      tick();
      check_eq({tag, "_done_hold"}, 128'(bus.done), 128'(1'b1));
      bus.start = 1'b0;
      tick();
      check_zero({tag, "_end"});
   endtask

   initial begin
      reset_n            = 1'b0;
      bus.start          = 1'b0;
      bus.StartIn        = 1'b0;
      bus.AccumlateIn    = 20'd0;
      bus.StoreAddressIn = 16'd0;
      bus.done_in        = 1'b0;
      repeat (3) tick();
      check_zero("reset");
      reset_n = 1'b1;
      tick();

      run_pass("ramp",  256, 16'h0000, 0, 20'd1);
      run_pass("lead0", 256, 16'h0000, 1, 20'd5);
      run_pass("sat",   256, 16'h0000, 2, 20'h10000);
      check_eq("sat_total_abs", 128'(exp_cdf(2, 255)), 128'(20'hFFFFF));
      run_pass("zero",  4,   16'h0100, 3, 20'd0);

      // Abort after beat 100; the abort cycle also carries a beat and done_in.
      wr_count  = 0;
      bus.start = 1'b1;
      for (int i = 0; i < 100; i++) begin
         drive_beat(0, i, 16'h0000);
         tick();
      end
      bus.start       = 1'b0;
      bus.StartIn     = 1'b1;
      bus.AccumlateIn = 20'd7;
      bus.done_in     = 1'b1;
      tick();
      check_zero("abort");
      check_eq("abort_writes", 128'(wr_count), 128'(100));
      bus.StartIn = 1'b0;
      bus.done_in = 1'b0;
      tick();
      check_zero("abort_idle");
      run_pass("after_abort", 256, 16'h0000, 0, 20'd1);

      run_pass("overrun", 260, 16'hFFF0, 0, 20'd1);

      // Synchronous reset on the cycle carrying beat 50.
      wr_count  = 0;
      bus.start = 1'b1;
      for (int i = 0; i < 49; i++) begin
         drive_beat(0, i, 16'h0000);
         tick();
      end
      bus.StartIn        = 1'b1;
      bus.AccumlateIn    = 20'd1;
      bus.StoreAddressIn = 16'd49;
      reset_n            = 1'b0;
      tick();
      check_zero("rst_mid");
      check_eq("rst_writes", 128'(wr_count), 128'(49));
      reset_n     = 1'b1;
      bus.StartIn = 1'b0;
      repeat (3) tick();
      check_zero("rst_idle");
      run_pass("after_rst", 256, 16'h0000, 0, 20'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
